// File: rtl/arty_board_pkg.sv
// Shared types and helpers for the Arty board housekeeping block.
// Reset-sequencer state encoding and counter width sizing.
package arty_board_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } rst_state_e;

  // Bits needed to hold values 0..max_val inclusive, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arty_board_ctrl_debounce.sv
// Single-input synchroniser and debouncer; latency SYNC_STAGES + DEBOUNCE_CYC + 1 cycles.
// Any excursion shorter than DEBOUNCE_CYC synced cycles is discarded.
module board_debounce
  import arty_board_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o
);

  localparam int               CNT_W    = cnt_w(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable_q, stable_d;
  logic                   level_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // The counter only runs while the synced input disagrees with the accepted level.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (synced != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      level_q  <= stable_q;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/arty_board_ctrl.sv
// Board housekeeping: debounced buttons/switches, SoC reset sequencing from PLL lock,
// fetch-enable gating and level / pulse-stretched LED drive.
module arty_board_ctrl
  import arty_board_pkg::*;
#(
  parameter int                 NUM_BTN      = 4,
  parameter int                 NUM_SW       = 4,
  parameter int                 NUM_LED      = 4,
  parameter int                 SYNC_STAGES  = 2,
  parameter int                 DEBOUNCE_CYC = 500000,
  parameter int                 RST_HOLD_CYC = 1024,
  parameter int                 STRETCH_CYC  = 2500000,
  parameter int                 RST_BTN_IDX  = 3,
  parameter int                 FETCH_SW_IDX = 3,
  parameter logic [NUM_LED-1:0] LED_MODE     = 4'b0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic [NUM_SW-1:0]  sw_i,
  input  logic [NUM_LED-1:0] led_src_i,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_SW-1:0]  sw_o,
  output logic               soc_rst_n_o,
  output logic               fetch_en_o,
  output logic [NUM_LED-1:0] led_o,
  output logic [1:0]         rst_state_o
);

  localparam int                HOLD_W    = cnt_w(RST_HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
  localparam int                STR_W     = cnt_w(STRETCH_CYC);
  localparam logic [STR_W-1:0]  STR_LOAD  = STR_W'(STRETCH_CYC);

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    board_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn_i[b]),
      .level_o(btn_o[b])
    );
  end

  for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
    board_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (sw_i[s]),
      .level_o(sw_o[s])
    );
  end

  logic [NUM_BTN-1:0] btn_prev_q, btn_press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q  <= '0;
      btn_press_q <= '0;
    end else begin
      btn_prev_q  <= btn_o;
      btn_press_q <= btn_o & ~btn_prev_q;
    end
  end

  assign btn_press_o = btn_press_q;

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  logic                   rst_btn;
  rst_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   soc_rst_n_q, fetch_en_q;

  assign lock_s  = lock_sync_q[SYNC_STAGES-1];
  assign rst_btn = btn_o[RST_BTN_IDX];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_RESET: state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (rst_btn) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (rst_btn) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Outputs are registered from next state so reset and fetch drop on the same edge;
  // requiring the current state too delays fetch one cycle behind reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= '0;
      state_q     <= ST_RESET;
      hold_cnt_q  <= '0;
      soc_rst_n_q <= 1'b0;
      fetch_en_q  <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      soc_rst_n_q <= (state_d == ST_RUN);
      fetch_en_q  <= (state_d == ST_RUN) && (state_q == ST_RUN) && sw_o[FETCH_SW_IDX];
    end
  end

  assign soc_rst_n_o = soc_rst_n_q;
  assign fetch_en_o  = fetch_en_q;
  assign rst_state_o = state_q;

  for (genvar i = 0; i < NUM_LED; i++) begin : g_led
    if (LED_MODE[i]) begin : g_stretch
      logic [1:0]       src_sync_q;
      logic             src_prev_q;
      logic [STR_W-1:0] cnt_q, cnt_d;

      // Each rising edge reloads, so a steady-high source only lights the LED once.
      always_comb begin
        cnt_d = cnt_q;
        if (src_sync_q[1] && !src_prev_q) begin
          cnt_d = STR_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - STR_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          src_sync_q <= '0;
          src_prev_q <= 1'b0;
          cnt_q      <= '0;
        end else begin
          src_sync_q <= {src_sync_q[0], led_src_i[i]};
          src_prev_q <= src_sync_q[1];
          cnt_q      <= cnt_d;
        end
      end

      assign led_o[i] = (cnt_q != '0);
    end else begin : g_level
      logic led_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          led_q <= 1'b0;
        end else begin
          led_q <= led_src_i[i];
        end
      end

      assign led_o[i] = led_q;
    end
  end

endmodule

// File: tb/tb_arty_board_ctrl.sv
// Directed bench for arty_board_ctrl with short debounce/hold/stretch constants.
module tb_arty_board_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked_i;
  logic [3:0] btn_i, sw_i, led_src_i;
  logic [3:0] btn_o, btn_press_o, sw_o, led_o;
  logic       soc_rst_n_o, fetch_en_o;
  logic [1:0] rst_state_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arty_board_ctrl #(
    .DEBOUNCE_CYC(8),
    .RST_HOLD_CYC(16),
    .STRETCH_CYC (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked_i(pll_locked_i),
    .btn_i       (btn_i),
    .sw_i        (sw_i),
    .led_src_i   (led_src_i),
    .btn_o       (btn_o),
    .btn_press_o (btn_press_o),
    .sw_o        (sw_o),
    .soc_rst_n_o (soc_rst_n_o),
    .fetch_en_o  (fetch_en_o),
    .led_o       (led_o),
    .rst_state_o (rst_state_o)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int   hi, pr, rises, rise_at, press_at, first_at, last_at;
    logic prev;

    rst_n        = 1'b0;
    pll_locked_i = 1'b1;
    btn_i        = '0;
    sw_i         = '0;
    led_src_i    = '0;
    tick(3);
    chk("rst_state", 32'(rst_state_o), 0);
    chk("rst_outputs", 32'({btn_o, btn_press_o, sw_o, led_o, soc_rst_n_o, fetch_en_o}), 0);

    // Startup: lock already high, sync takes two cycles, hold 16.
    rst_n = 1'b1;
    tick(1); chk("boot_wait_lock_1", 32'(rst_state_o), 1);
    tick(1); chk("boot_wait_lock_2", 32'(rst_state_o), 1);
    tick(1); chk("boot_hold_entry", 32'(rst_state_o), 2);
    tick(15);
    chk("boot_hold_last_state", 32'(rst_state_o), 2);
    chk("boot_hold_last_rst", 32'(soc_rst_n_o), 0);
    tick(1);
    chk("boot_run_state", 32'(rst_state_o), 3);
    chk("boot_run_rst", 32'(soc_rst_n_o), 1);
    chk("boot_fetch_sw_off", 32'(fetch_en_o), 0);

    // Fetch switch: debounce latency 2 + 8 + 1.
    sw_i[3] = 1'b1;
    tick(10); chk("sw_before_latency", 32'(sw_o), 0);
    tick(1);
    chk("sw_debounced", 32'(sw_o), 32'h8);
    chk("fetch_not_yet", 32'(fetch_en_o), 0);
    tick(1); chk("fetch_on", 32'(fetch_en_o), 1);

    // 5-cycle glitch on btn 0 must never appear.
    hi = 0; pr = 0;
    for (int c = 0; c < 35; c++) begin
      btn_i[0] = (c < 5);
      tick(1);
      hi += int'(btn_o[0]);
      pr += int'(btn_press_o[0]);
    end
    chk("glitch_level", hi, 0);
    chk("glitch_press", pr, 0);

    // 20-cycle press: one rise at cycle 11, one press pulse at cycle 12.
    rises = 0; pr = 0; rise_at = -1; press_at = -1; prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      btn_i[0] = (c < 20);
      tick(1);
      if (btn_o[0] && !prev) begin
        rises++;
        if (rise_at < 0) rise_at = c + 1;
      end
      prev = btn_o[0];
      if (btn_press_o[0]) begin
        pr++;
        if (press_at < 0) press_at = c + 1;
      end
    end
    chk("press_rises", rises, 1);
    chk("press_pulses", pr, 1);
    chk("press_rise_cycle", rise_at, 11);
    chk("press_pulse_cycle", press_at, 12);
    chk("press_released", 32'(btn_o[0]), 0);
    chk("press_no_reset", 32'(rst_state_o), 3);

    // Level LED follows source one cycle later.
    led_src_i[0] = 1'b1;
    tick(1); chk("led_level_on", 32'(led_o), 32'h1);
    led_src_i[0] = 1'b0;
    tick(1); chk("led_level_off", 32'(led_o), 0);

    // Stretch LED: steady-high source lights exactly 10 cycles.
    led_src_i[2] = 1'b1;
    tick(2); chk("stretch_pre", 32'(led_o[2]), 0);
    tick(1); chk("stretch_first", 32'(led_o[2]), 1);
    tick(9); chk("stretch_last", 32'(led_o[2]), 1);
    tick(1); chk("stretch_expired", 32'(led_o[2]), 0);
    tick(1); chk("stretch_held_dark", 32'(led_o[2]), 0);
    led_src_i[2] = 1'b0;
    tick(5);

    // Retrigger six cycles after the first edge extends on-time to 16.
    hi = 0; first_at = -1; last_at = -1;
    for (int c = 0; c < 25; c++) begin
      led_src_i[2] = (c < 2) || (c >= 6 && c < 8);
      tick(1);
      if (led_o[2]) begin
        hi++;
        if (first_at < 0) first_at = c + 1;
        last_at = c + 1;
      end
    end
    chk("retrig_count", hi, 16);
    chk("retrig_first", first_at, 3);
    chk("retrig_last", last_at, 18);

    // Lock drop for three cycles in RUN.
    pll_locked_i = 1'b0;
    tick(1); chk("lockdrop_c1", 32'({rst_state_o, soc_rst_n_o, fetch_en_o}), 32'hF);
    tick(1); chk("lockdrop_c2", 32'({rst_state_o, soc_rst_n_o, fetch_en_o}), 32'hF);
    tick(1); chk("lockdrop_fall", 32'({rst_state_o, soc_rst_n_o, fetch_en_o}), 32'h4);
    pll_locked_i = 1'b1;
    tick(2); chk("relock_wait", 32'(rst_state_o), 1);
    tick(1); chk("relock_hold", 32'(rst_state_o), 2);
    tick(15); chk("relock_hold_last", 32'({rst_state_o, soc_rst_n_o}), 32'h4);
    tick(1); chk("relock_run", 32'({rst_state_o, soc_rst_n_o, fetch_en_o}), 32'hE);
    tick(1); chk("relock_fetch", 32'(fetch_en_o), 1);

    // Reset button held 30 cycles.
    btn_i[3] = 1'b1;
    tick(11); chk("rstbtn_still_run", 32'(rst_state_o), 3);
    tick(1);
    chk("rstbtn_hold", 32'({rst_state_o, soc_rst_n_o, fetch_en_o}), 32'h8);
    chk("rstbtn_press", 32'(btn_press_o), 32'h8);
    tick(18);
    btn_i[3] = 1'b0;
    tick(10); chk("rstbtn_held", 32'(rst_state_o), 2);
    tick(16); chk("rstbtn_release_last", 32'({rst_state_o, soc_rst_n_o}), 32'h4);
    tick(1); chk("rstbtn_run", 32'({rst_state_o, soc_rst_n_o, fetch_en_o}), 32'hE);
    tick(1); chk("rstbtn_fetch", 32'(fetch_en_o), 1);

    // Async reset mid-HOLD and mid-stretch.
    btn_i[3] = 1'b1;
    tick(12); chk("areset_in_hold", 32'(rst_state_o), 2);
    led_src_i = 4'b0101;
    tick(5);
    chk("areset_pre_led", 32'(led_o), 32'h5);
    chk("areset_pre_btn", 32'(btn_o), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_state", 32'(rst_state_o), 0);
    chk("areset_outputs", 32'({btn_o, btn_press_o, sw_o, led_o, soc_rst_n_o, fetch_en_o}), 0);
    tick(2);
    chk("areset_held", 32'({rst_state_o, btn_o, btn_press_o, sw_o, led_o, soc_rst_n_o, fetch_en_o}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
